// File: rtl/coeff_sequencer.sv
// rtl/coeff_sequencer.sv - coefficient register file with handshaked readout, descending by default
// Optional macro COEFF_ASCEND_EN adds the ascend input for index 0..degree readout order.
module coeff_sequencer #(
  parameter int WIDTH  = 32,
  parameter int NCOEFF = 11,
  parameter int IDXW   = 4
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [IDXW-1:0]  degree,
`ifdef COEFF_ASCEND_EN
  input  logic             ascend,
`endif
  input  logic             ready,
  output logic [WIDTH-1:0] coeff,
  output logic [IDXW-1:0]  coeff_idx,
  output logic             coeff_valid,
  output logic             coeff_last,
  output logic             busy,
  output logic             done,
  output logic             wr_drop
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // One extra bit so NCOEFF == 2^IDXW still compares correctly.
  localparam logic [IDXW:0]   LP_NCOEFF  = (IDXW+1)'(NCOEFF);
  localparam logic [IDXW-1:0] LP_MAX_IDX = IDXW'(NCOEFF - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_coef [NCOEFF];
  logic             r_asc;
  logic [IDXW-1:0]  r_deg;

  logic             w_start_asc;
  logic             w_wr_ok;
  logic             w_first_last;
  logic             w_next_last;
  logic [IDXW-1:0]  w_deg;
  logic [IDXW-1:0]  w_first;
  logic [IDXW-1:0]  w_next;

  always_comb begin
`ifdef COEFF_ASCEND_EN
    w_start_asc = ascend;
`else
    w_start_asc = 1'b0;
`endif
    w_deg        = ({1'b0, degree} >= LP_NCOEFF) ? LP_MAX_IDX : degree;
    w_first      = w_start_asc ? '0 : w_deg;
    w_first_last = (w_deg == '0);
    w_next       = r_asc ? (coeff_idx + IDXW'(1)) : (coeff_idx - IDXW'(1));
    w_next_last  = r_asc ? (w_next == r_deg) : (w_next == '0);
    w_wr_ok      = (r_state == S_IDLE) && ({1'b0, wr_addr} < LP_NCOEFF);
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state     <= S_IDLE;
      for (int k = 0; k < NCOEFF; k++) r_coef[k] <= '0;
      r_asc       <= 1'b0;
      r_deg       <= '0;
      coeff       <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
      coeff_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_drop <= 1'b0;
      if (wr_en) begin
        if (w_wr_ok) r_coef[wr_addr] <= wr_data;
        else         wr_drop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // The first beat reads the array before this edge's write lands.
          if (start) begin
            r_state     <= S_RUN;
            r_asc       <= w_start_asc;
            r_deg       <= w_deg;
            coeff       <= r_coef[w_first];
            coeff_idx   <= w_first;
            coeff_valid <= 1'b1;
            coeff_last  <= w_first_last;
            busy        <= 1'b1;
          end
        end
        S_RUN: begin
          if (ready) begin
            if (coeff_last) begin
              r_state     <= S_DONE;
              coeff_valid <= 1'b0;
              coeff_last  <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              coeff      <= r_coef[w_next];
              coeff_idx  <= w_next;
              coeff_last <= w_next_last;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_sequencer.sv
// tb/tb_coeff_sequencer.sv - self-checking bench for coeff_sequencer
// Expected beats come from a coefficient array model; readout order follows the degree/ascend rules.
module tb_coeff_sequencer;
  localparam int W  = 32;
  localparam int N  = 11;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [IW-1:0] degree;
  logic          ready;
  logic [W-1:0]  coeff;
  logic [IW-1:0] coeff_idx;
  logic          coeff_valid, coeff_last, busy, done, wr_drop;
`ifdef COEFF_ASCEND_EN
  logic          ascend;
`endif

  always #5 clk = ~clk;

  coeff_sequencer #(.WIDTH(W), .NCOEFF(N), .IDXW(IW)) dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .degree(degree),
`ifdef COEFF_ASCEND_EN
    .ascend(ascend),
`endif
    .ready(ready), .coeff(coeff), .coeff_idx(coeff_idx), .coeff_valid(coeff_valid),
    .coeff_last(coeff_last), .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  typedef struct {
    logic [W-1:0]  v;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] mem [N];
  int           n_chk = 0;
  int           n_fail = 0;
  logic         done_pend = 1'b0;
  logic         drop_pend = 1'b0;
  logic         wr_exp_drop = 1'b0;
  logic         chk_en = 1'b0;
  logic [W-1:0] last_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void build(input int deg, input bit asc);
    int    d;
    int    idx;
    beat_t b;
    d = (deg >= N) ? N - 1 : deg;
    for (int k = 0; k <= d; k++) begin
      idx = asc ? k : d - k;
      b.v = mem[idx];
      b.i = IW'(idx);
      b.l = (k == d);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && !GlobalReset) begin
      check("done", done, done_pend);
      done_pend = 1'b0;
      check("wr_drop", wr_drop, drop_pend);
      drop_pend = wr_en && wr_exp_drop;
      if (!start) begin
        check("busy", busy, exp_q.size() != 0);
        check("coeff_valid", coeff_valid, exp_q.size() != 0);
      end
      if (coeff_valid && exp_q.size() > 0) begin
        check("coeff", coeff, exp_q[0].v);
        check("coeff_idx", coeff_idx, exp_q[0].i);
        check("coeff_last", coeff_last, exp_q[0].l);
        if (ready) begin
          last_val  = exp_q[0].v;
          done_pend = exp_q[0].l;
          void'(exp_q.pop_front());
        end
      end else if (!coeff_valid) begin
        check("coeff_hold", coeff, last_val);
      end
    end
  end

  // All tasks are entered and left 1ns after a rising edge.
  task automatic pulse_start(input int deg, input bit asc);
    start  = 1'b1;
    degree = deg[IW-1:0];
`ifdef COEFF_ASCEND_EN
    ascend = asc;
`endif
    if (exp_q.size() == 0 && !done_pend) build(deg, asc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [W-1:0] data, input bit exp_drop);
    wr_en = 1'b1; wr_addr = addr[IW-1:0]; wr_data = data; wr_exp_drop = exp_drop;
    if (!exp_drop) mem[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_write(input int deg, input int addr, input logic [W-1:0] data);
    wr_en = 1'b1; wr_addr = addr[IW-1:0]; wr_data = data; wr_exp_drop = 1'b0;
    start = 1'b1; degree = deg[IW-1:0];
`ifdef COEFF_ASCEND_EN
    ascend = 1'b0;
`endif
    build(deg, 1'b0);
    mem[addr] = data;
    for (int k = 1; k < exp_q.size(); k++)
      if (exp_q[k].i == addr[IW-1:0]) exp_q[k].v = data;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_done(input int mode);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || done_pend) && cyc < 200) begin
      ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("seq_timeout", cyc >= 200, 0);
    ready = 1'b1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    done_pend = 1'b0; drop_pend = 1'b0; last_val = '0;
    for (int k = 0; k < N; k++) mem[k] = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    GlobalReset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; degree = '0; ready = 1'b1;
`ifdef COEFF_ASCEND_EN
    ascend = 1'b0;
`endif
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_coeff", coeff, 0);
    check("rst_idx", coeff_idx, 0);
    check("rst_valid", coeff_valid, 0);
    check("rst_last", coeff_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", wr_drop, 0);
    GlobalReset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) do_write(k, 32'h100 + k, 1'b0);

    // Full descending readout with ready held high
    pulse_start(10, 1'b0);
    check("lit_first_val", coeff, 32'h10A);
    check("lit_first_idx", coeff_idx, 10);
    wait_done(0);
    check("lit_hold_after", coeff, 32'h100);

    // Backpressure 1,0,0 pattern
    pulse_start(3, 1'b0);
    check("lit_d3_first", coeff, 32'h103);
    wait_done(1);
    check("lit_d3_hold", coeff, 32'h100);

    // Dropped writes: during busy and out of range
    ready = 1'b0;
    pulse_start(10, 1'b0);
    do_write(2, 32'hDEAD, 1'b1);
    wait_done(0);
    do_write(12, 32'hBEEF, 1'b1);
    pulse_start(10, 1'b0);
    wait_done(0);
    check("lit_mem2_kept", mem[2], 32'h102);

    // Degree clamp and single-beat sequence
    pulse_start(15, 1'b0);
    check("lit_clamp_idx", coeff_idx, 10);
    check("lit_clamp_val", coeff, 32'h10A);
    wait_done(0);
    pulse_start(0, 1'b0);
    check("lit_d0_val", coeff, 32'h100);
    check("lit_d0_last", coeff_last, 1);
    wait_done(0);

    // Start ignored while busy and in DONE, accepted in the IDLE cycle after
    pulse_start(1, 1'b0);
    pulse_start(5, 1'b0);
    pulse_start(5, 1'b0);
    pulse_start(2, 1'b0);
    pulse_start(2, 1'b0);
    check("lit_restart_idx", coeff_idx, 2);
    wait_done(0);

    // Simultaneous start and write
    start_write(10, 10, 32'h55);
    check("lit_sw_first_old", coeff, 32'h10A);
    wait_done(0);
    start_write(10, 5, 32'h66);
    check("lit_sw_first_new", coeff, 32'h55);
    wait_done(0);

    // Asynchronous reset in the middle of a sequence
    pulse_start(10, 1'b0);
    @(posedge clk); #1;
    #2;
    GlobalReset = 1'b1;
    start = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h77;
    #1;
    check("mid_rst_coeff", coeff, 0);
    check("mid_rst_valid", coeff_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", coeff_idx, 0);
    reset_model();
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    GlobalReset = 1'b0;
    @(posedge clk); #1;
    pulse_start(2, 1'b0);
    check("lit_post_rst_val", coeff, 0);
    check("lit_post_rst_idx", coeff_idx, 2);
    wait_done(0);

`ifdef COEFF_ASCEND_EN
    for (int k = 0; k < 3; k++) do_write(k, 32'h100 + k, 1'b0);
    pulse_start(2, 1'b1);
    check("lit_asc_first_val", coeff, 32'h100);
    check("lit_asc_first_idx", coeff_idx, 0);
    wait_done(0);
    check("lit_asc_hold", coeff, 32'h102);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
